// File: rtl/aes_sbox_sched.sv
// aes_sbox_sched: shares one combinational AES S-box between the round
// datapath's SubBytes (16-byte state) and key expansion's SubWord (4-byte word).
// It does one lookup per clock and returns each result on a valid/ready port.
module aes_sbox_sched #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned STATE_BYTES = 16,
  parameter int unsigned KEY_BYTES   = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [STATE_BYTES*DATA_WIDTH-1:0] st_in,
  input  logic                              st_in_valid,
  output logic                              st_in_ready,
  output logic [STATE_BYTES*DATA_WIDTH-1:0] st_out,
  output logic                              st_out_valid,
  input  logic                              st_out_ready,
  input  logic [KEY_BYTES*DATA_WIDTH-1:0]   kw_in,
  input  logic                              kw_in_valid,
  output logic                              kw_in_ready,
  output logic [KEY_BYTES*DATA_WIDTH-1:0]   kw_out,
  output logic                              kw_out_valid,
  input  logic                              kw_out_ready,
  output logic [3:0]                        sbox_row,
  output logic [3:0]                        sbox_col,
  input  logic [DATA_WIDTH-1:0]             sbox_out
);

  localparam int unsigned SW = STATE_BYTES * DATA_WIDTH;
  localparam int unsigned KW = KEY_BYTES * DATA_WIDTH;
  localparam logic [3:0]  ST_LAST = 4'(STATE_BYTES - 1);
  localparam logic [3:0]  KW_LAST = 4'(KEY_BYTES - 1);

  typedef enum logic [2:0] {IDLE, SUB_ST, SUB_KW, DONE_ST, DONE_KW} state_e;
  typedef enum logic {GRANT_ST, GRANT_KW} grant_e;

  state_e          state_q, state_d;
  grant_e          last_q, last_d;
  logic [3:0]      idx_q, idx_d;
  logic [SW-1:0]   work_q, work_d;
  logic [SW-1:0]   st_res_q, st_res_d;
  logic [KW-1:0]   kw_res_q, kw_res_d;
  logic            st_vld_q, st_vld_d;
  logic            kw_vld_q, kw_vld_d;
  logic [DATA_WIDTH-1:0] cur_byte;
  logic            busy;
  logic            idle;

  // Work register is left-aligned for both job types and shifts one byte per
  // lookup, so the byte being looked up is always the top byte.  A key word
  // occupies the upper 32 bits of the work register.
  assign cur_byte = work_q[SW-1 -: DATA_WIDTH];
  assign busy     = (state_q == SUB_ST) || (state_q == SUB_KW);
  assign idle     = (state_q == IDLE);

  // S-box address: current work byte while substituting, zero otherwise.
  always_comb begin
    sbox_row = '0;
    sbox_col = '0;
    if (busy) begin
      sbox_row = cur_byte[7:4];
      sbox_col = cur_byte[3:0];
    end
  end

  // Alternating grant: the key side only gets ready when it is requesting and
  // has priority; the state side takes ready otherwise, so the two readys are
  // never high together.  Readys are held low while reset is asserted.
  always_comb begin
    kw_in_ready = rst_n & idle & kw_in_valid & (~st_in_valid | (last_q == GRANT_ST));
    st_in_ready = rst_n & idle & ~kw_in_ready;
  end

  assign st_out       = st_res_q;
  assign kw_out       = kw_res_q;
  assign st_out_valid = st_vld_q;
  assign kw_out_valid = kw_vld_q;

  // Next-state logic: grant/capture, byte-serial substitution, result hold.
  // Results are assembled by shifting sbox_out in at the bottom, which leaves
  // byte0 at the top after the final lookup.
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    idx_d    = idx_q;
    work_d   = work_q;
    st_res_d = st_res_q;
    kw_res_d = kw_res_q;
    st_vld_d = st_vld_q;
    kw_vld_d = kw_vld_q;
    case (state_q)
      IDLE: begin
        if (kw_in_valid && kw_in_ready) begin
          work_d  = {kw_in, {(SW-KW){1'b0}}};
          idx_d   = '0;
          last_d  = GRANT_KW;
          state_d = SUB_KW;
        end else if (st_in_valid && st_in_ready) begin
          work_d  = st_in;
          idx_d   = '0;
          last_d  = GRANT_ST;
          state_d = SUB_ST;
        end
      end
      SUB_ST: begin
        work_d   = work_q << DATA_WIDTH;
        st_res_d = {st_res_q[SW-DATA_WIDTH-1:0], sbox_out};
        idx_d    = idx_q + 4'd1;
        if (idx_q == ST_LAST) begin
          idx_d    = '0;
          st_vld_d = 1'b1;
          state_d  = DONE_ST;
        end
      end
      SUB_KW: begin
        work_d   = work_q << DATA_WIDTH;
        kw_res_d = {kw_res_q[KW-DATA_WIDTH-1:0], sbox_out};
        idx_d    = idx_q + 4'd1;
        if (idx_q == KW_LAST) begin
          idx_d    = '0;
          kw_vld_d = 1'b1;
          state_d  = DONE_KW;
        end
      end
      DONE_ST: begin
        if (st_out_ready) begin
          st_vld_d = 1'b0;
          state_d  = IDLE;
        end
      end
      DONE_KW: begin
        if (kw_out_ready) begin
          kw_vld_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any job in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      last_q   <= GRANT_ST;
      idx_q    <= '0;
      work_q   <= '0;
      st_res_q <= '0;
      kw_res_q <= '0;
      st_vld_q <= 1'b0;
      kw_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      idx_q    <= idx_d;
      work_q   <= work_d;
      st_res_q <= st_res_d;
      kw_res_q <= kw_res_d;
      st_vld_q <= st_vld_d;
      kw_vld_q <= kw_vld_d;
    end
  end

endmodule

// File: tb/tb_aes_sbox_sched.sv
// Directed bench for aes_sbox_sched; the S-box table is computed from
// GF(2^8) inversion plus the AES affine map.
module tb_aes_sbox_sched;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] st_in;
  logic         st_in_valid, st_in_ready;
  logic [127:0] st_out;
  logic         st_out_valid, st_out_ready;
  logic [31:0]  kw_in;
  logic         kw_in_valid, kw_in_ready;
  logic [31:0]  kw_out;
  logic         kw_out_valid, kw_out_ready;
  logic [3:0]   sbox_row, sbox_col;
  logic [7:0]   sbox_out;

  int n_checks = 0;
  int n_fail   = 0;
  int lat;

  localparam logic [127:0] ST_A  = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] ST_AE = 128'h637C777BF26B6FC53001672BFED7AB76;
  localparam logic [127:0] ST_B  = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] ST_BE = 128'h638293C31BFC33F5C4EEACEA4BC12816;
  localparam logic [31:0]  KW_A  = 32'h00102030;
  localparam logic [31:0]  KW_AE = 32'h63CAB704;

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = '0; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p ^= aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_fn(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  assign sbox_out = sbox_fn({sbox_row, sbox_col});

  aes_sbox_sched #(.DATA_WIDTH(8), .STATE_BYTES(16), .KEY_BYTES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .st_in(st_in), .st_in_valid(st_in_valid), .st_in_ready(st_in_ready),
    .st_out(st_out), .st_out_valid(st_out_valid), .st_out_ready(st_out_ready),
    .kw_in(kw_in), .kw_in_valid(kw_in_valid), .kw_in_ready(kw_in_ready),
    .kw_out(kw_out), .kw_out_valid(kw_out_valid), .kw_out_ready(kw_out_ready),
    .sbox_row(sbox_row), .sbox_col(sbox_col), .sbox_out(sbox_out)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in cycle T+1; returns the cycle offset at which valid was seen.
  task automatic wait_valid(input bit kw, output int n);
    n = 1;
    while (((kw ? kw_out_valid : st_out_valid) !== 1'b1) && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_out"}, {st_out ^ {kw_out, 96'h0}, st_out[31:0] | kw_out}, '0);
    chk({tag, "_ctl"}, {st_out_valid, kw_out_valid, st_in_ready, kw_in_ready,
                        sbox_row, sbox_col}, '0);
  endtask

  initial begin
    rst_n = 1'b0;
    st_in = '0; st_in_valid = 1'b0; st_out_ready = 1'b0;
    kw_in = '0; kw_in_valid = 1'b0; kw_out_ready = 1'b0;
    #2;
    chk_all_zero("reset");
    tick();
    rst_n = 1'b1;
    #1;

    // 1: state job alone
    st_in = ST_A; st_in_valid = 1'b1;
    #1;
    chk("t1_st_ready", st_in_ready, 1'b1);
    tick();
    st_in_valid = 1'b0;
    wait_valid(1'b0, lat);
    chk("t1_st_latency", lat, 17);
    chk("t1_st_out", st_out, ST_AE);
    st_out_ready = 1'b1;
    tick();
    st_out_ready = 1'b0;
    chk("t1_valid_drop", st_out_valid, 1'b0);
    chk("t1_data_kept", st_out, ST_AE);

    // 2: key job alone, row sequence during substitution
    kw_in = KW_A; kw_in_valid = 1'b1;
    #1;
    chk("t2_readys", {kw_in_ready, st_in_ready}, 2'b10);
    tick();
    kw_in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t2_row%0d", i), {kw_out_valid, sbox_row}, {1'b0, 4'(i)});
      tick();
    end
    chk("t2_kw_valid_t5", kw_out_valid, 1'b1);
    chk("t2_kw_out", kw_out, KW_AE);
    kw_out_ready = 1'b1;
    tick();
    kw_out_ready = 1'b0;
    chk("t2_valid_drop", kw_out_valid, 1'b0);

    // 3: both requesting after reset -> key, state, key
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    st_in = ST_A; kw_in = KW_A;
    st_in_valid = 1'b1; kw_in_valid = 1'b1;
    st_out_ready = 1'b1; kw_out_ready = 1'b1;
    #1;
    chk("t3_grant1_key", {kw_in_ready, st_in_ready}, 2'b10);
    tick();
    wait_valid(1'b1, lat);
    chk("t3_kw_latency", lat, 5);
    chk("t3_kw_out1", kw_out, KW_AE);
    tick();
    chk("t3_grant2_state", {kw_in_ready, st_in_ready}, 2'b01);
    tick();
    wait_valid(1'b0, lat);
    chk("t3_st_latency", lat, 17);
    chk("t3_st_out", st_out, ST_AE);
    tick();
    chk("t3_grant3_key", {kw_in_ready, st_in_ready}, 2'b10);
    tick();
    wait_valid(1'b1, lat);
    chk("t3_kw_latency2", lat, 5);
    st_in_valid = 1'b0; kw_in_valid = 1'b0;
    tick();
    st_out_ready = 1'b0; kw_out_ready = 1'b0;

    // 4 + 6: back-pressure, pending requests, input changed mid-job
    st_in = ST_B; st_in_valid = 1'b1;
    #1;
    chk("t4_st_ready", st_in_ready, 1'b1);
    tick();
    st_in = '1; kw_in_valid = 1'b1;
    wait_valid(1'b0, lat);
    chk("t4_st_latency", lat, 17);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t4_hold%0d_ctl", i), {st_out_valid, st_in_ready, kw_in_ready}, 3'b100);
      chk($sformatf("t4_hold%0d_data", i), st_out, ST_BE);
      tick();
    end
    st_out_ready = 1'b1;
    tick();
    st_out_ready = 1'b0;
    chk("t4_valid_drop", st_out_valid, 1'b0);
    chk("t4_next_grant", {kw_in_ready, st_in_ready}, 2'b10);
    st_in_valid = 1'b0; kw_in_valid = 1'b0;
    tick();

    // 5: reset in the middle of a state job
    st_in = ST_A; st_in_valid = 1'b1;
    tick();
    st_in_valid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk("t5_idx7_addr", {sbox_row, sbox_col}, 8'h07);
    rst_n = 1'b0;
    #1;
    chk_all_zero("t5_reset");
    tick();
    rst_n = 1'b1;
    st_in = ST_B; st_in_valid = 1'b1;
    #1;
    chk("t5_ready_after", st_in_ready, 1'b1);
    tick();
    st_in_valid = 1'b0;
    wait_valid(1'b0, lat);
    chk("t5_st_latency", lat, 17);
    chk("t5_st_out", st_out, ST_BE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
